// File: rtl/video_position_adjust.sv
// Centres a core's picture on a CRT: pixel data is delayed by a fixed 8 pixels while the
// sync pair is re-timed by signed pixel/line offsets; frame timing is measured for lock.
module video_position_adjust #(
   parameter int COLOR_DEPTH = 6,
   parameter int LINE_BITS   = 11
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic                   ce_pix,
   input  logic                   enable,
   input  logic [3:0]             h_adj,
   input  logic [3:0]             v_adj,
   input  logic [COLOR_DEPTH-1:0] R,
   input  logic [COLOR_DEPTH-1:0] G,
   input  logic [COLOR_DEPTH-1:0] B,
   input  logic                   HSync,
   input  logic                   VSync,
   output logic [COLOR_DEPTH-1:0] R_out,
   output logic [COLOR_DEPTH-1:0] G_out,
   output logic [COLOR_DEPTH-1:0] B_out,
   output logic                   HSync_out,
   output logic                   VSync_out,
   output logic                   locked,
   output logic [LINE_BITS-1:0]   frame_lines
);

   localparam int PIX_W   = 3 * COLOR_DEPTH;
   localparam int PIX_DLY = 8;
   localparam int TAPS    = 16;
   localparam logic [LINE_BITS-1:0] LINE_MAX = '1;

   typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

   function automatic logic [LINE_BITS-1:0] sat_inc(input logic [LINE_BITS-1:0] v);
      return (v == LINE_MAX) ? v : v + 1'b1;
   endfunction

   logic [PIX_W-1:0]     pix_sr_p0 [0:PIX_DLY-1];
   logic [1:0]           sync_sr_p0 [0:TAPS-2];
   logic [1:0]           sync_line [0:TAPS-1];
   logic [1:0]           sync_tap;
   logic [3:0]           tap_idx;

   logic signed [3:0]    h_eff;
   logic signed [3:0]    v_eff;
   logic                 hs_in_prev;
   logic                 vs_in_prev;
   logic                 hs_fall;
   logic                 vs_fall;

   logic [LINE_BITS-1:0] in_line;
   logic [LINE_BITS-1:0] in_line_inc;
   logic [LINE_BITS-1:0] vs_cnt;
   logic [LINE_BITS-1:0] vs_lines;

   lock_state_t          lock_state;
   lock_state_t          lock_next;

   logic                 tap_hs;
   logic                 tap_vs;
   logic                 tap_vs_prev;
   logic                 dhs_fall;
   logic                 dvs_fall;
   logic [LINE_BITS-1:0] out_line;
   logic [LINE_BITS-1:0] out_line_inc;
   logic [LINE_BITS:0]   out_line_wide;
   logic [LINE_BITS-1:0] start_line;
   logic [LINE_BITS-1:0] v_ext;
   logic [LINE_BITS-1:0] regen_left;
   logic                 regen_on;

   // ---- Stage p0: fixed pixel delay and sync delay line ----
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PIX_DLY; i++) pix_sr_p0[i] <= '0;
         for (int i = 0; i < TAPS - 1; i++) sync_sr_p0[i] <= 2'b11;
         {R_out, G_out, B_out} <= '0;
      end else if (ce_pix) begin
         pix_sr_p0[0] <= {R, G, B};
         for (int i = 1; i < PIX_DLY; i++) pix_sr_p0[i] <= pix_sr_p0[i-1];
         sync_sr_p0[0] <= {HSync, VSync};
         for (int i = 1; i < TAPS - 1; i++) sync_sr_p0[i] <= sync_sr_p0[i-1];
         {R_out, G_out, B_out} <= pix_sr_p0[PIX_DLY-1];
      end
   end

   // Tap 0 is the live input, so an offset of -8 gives zero extra delay.
   always_comb begin
      sync_line[0] = {HSync, VSync};
      for (int i = 1; i < TAPS; i++) sync_line[i] = sync_sr_p0[i-1];
   end

   assign tap_idx  = {~h_eff[3], h_eff[2:0]};
   assign sync_tap = sync_line[tap_idx];
   assign tap_hs   = sync_tap[1];
   assign tap_vs   = sync_tap[0];

   // ---- Input timing measurement and offset capture ----
   assign hs_fall = ce_pix & hs_in_prev & ~HSync;
   assign vs_fall = ce_pix & vs_in_prev & ~VSync;

   always_comb begin
      in_line_inc = in_line;
      if (hs_fall) in_line_inc = sat_inc(in_line);
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         hs_in_prev  <= 1'b1;
         vs_in_prev  <= 1'b1;
         in_line     <= '0;
         vs_cnt      <= '0;
         vs_lines    <= '0;
         frame_lines <= '0;
         h_eff       <= 4'sd0;
         v_eff       <= 4'sd0;
      end else if (ce_pix) begin
         hs_in_prev <= HSync;
         vs_in_prev <= VSync;
         if (vs_fall) begin
            // A line starting on the VS edge belongs to the frame that is ending.
            frame_lines <= in_line_inc;
            vs_lines    <= (vs_cnt == '0) ? LINE_BITS'(1) : vs_cnt;
            in_line     <= '0;
            vs_cnt      <= '0;
            h_eff       <= enable ? $signed(h_adj) : 4'sd0;
            v_eff       <= enable ? $signed(v_adj) : 4'sd0;
         end else begin
            in_line <= in_line_inc;
            if (hs_fall && !VSync) vs_cnt <= sat_inc(vs_cnt);
         end
      end
   end

   // ---- Lock state machine ----
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) lock_state <= UNLOCKED;
      else if (ce_pix) lock_state <= lock_next;
   end

   always_comb begin
      lock_next = lock_state;
      if (vs_fall) begin
         if (in_line_inc == frame_lines && in_line_inc >= LINE_BITS'(16) &&
             in_line_inc <= LINE_MAX - 1'b1)
            lock_next = LOCKED;
         else
            lock_next = UNLOCKED;
      end
   end

   assign locked = (lock_state == LOCKED);

   // ---- Stage p1: sync outputs and vertical regeneration ----
   assign dhs_fall      = HSync_out & ~tap_hs;
   assign dvs_fall      = tap_vs_prev & ~tap_vs;
   assign out_line_wide = {1'b0, out_line} + 1'b1;
   assign out_line_inc  = (out_line_wide >= {1'b0, frame_lines}) ? '0
                                                                  : out_line_wide[LINE_BITS-1:0];
   assign v_ext         = {{(LINE_BITS-4){v_eff[3]}}, v_eff};
   assign start_line    = v_eff[3] ? frame_lines + v_ext : v_ext;
   assign regen_on      = locked && (v_eff != 4'sd0);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         HSync_out   <= 1'b1;
         VSync_out   <= 1'b1;
         tap_vs_prev <= 1'b1;
         out_line    <= '0;
         regen_left  <= '0;
      end else if (ce_pix) begin
         HSync_out   <= tap_hs;
         tap_vs_prev <= tap_vs;
         if (dvs_fall)      out_line <= '0;
         else if (dhs_fall) out_line <= out_line_inc;

         if (!regen_on) begin
            VSync_out  <= tap_vs;
            regen_left <= '0;
         end else if (dhs_fall) begin
            // A pulse inherited from the tapped path ends on the next line (no stuck low).
            if (!VSync_out) begin
               if (regen_left <= LINE_BITS'(1)) VSync_out <= 1'b1;
               if (regen_left != '0) regen_left <= regen_left - 1'b1;
            end else if (!dvs_fall && out_line_inc == start_line) begin
               VSync_out  <= 1'b0;
               regen_left <= vs_lines;
            end
         end
      end
   end

endmodule

// File: tb/tb_video_position_adjust.sv
// Directed bench for video_position_adjust: RGB scoreboard queue plus a behavioural
// model of sync shifting, frame measurement and lock.
`timescale 1ns/1ps
module tb_video_position_adjust;

   localparam int CD = 6;
   localparam int LB = 11;
   localparam int PW = 3 * CD;
   localparam int HN = 16384;

   logic          clk_sys = 1'b0;
   logic          reset   = 1'b1;
   logic          ce_pix  = 1'b0;
   logic          enable  = 1'b1;
   logic [3:0]    h_adj   = 4'd0;
   logic [3:0]    v_adj   = 4'd0;
   logic [CD-1:0] R = '0, G = '0, B = '0;
   logic          HSync = 1'b1, VSync = 1'b1;
   logic [CD-1:0] R_out, G_out, B_out;
   logic          HSync_out, VSync_out, locked;
   logic [LB-1:0] frame_lines;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_sys = ~clk_sys;

   video_position_adjust #(.COLOR_DEPTH(CD), .LINE_BITS(LB)) dut (
      .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .enable(enable),
      .h_adj(h_adj), .v_adj(v_adj), .R(R), .G(G), .B(B),
      .HSync(HSync), .VSync(VSync),
      .R_out(R_out), .G_out(G_out), .B_out(B_out),
      .HSync_out(HSync_out), .VSync_out(VSync_out),
      .locked(locked), .frame_lines(frame_lines)
   );

   logic [PW-1:0] rgb_q[$];
   bit            hs_hist [0:HN-1];
   bit            vs_hist [0:HN-1];
   int            line_hist [0:HN-1];
   int            n_pulse = 0;

   int h_m = 0, v_m = 0, fl_m = 0, vsl_m = 0, cnt_m = 0, vcnt_m = 0, line_m = 0;
   bit lock_m = 0, phs_m = 1, pvs_m = 1;
   logic [PW-1:0] e_rgb = '0;
   logic          e_hs = 1'b1, e_vs = 1'b1, e_lock = 1'b0;
   logic [LB-1:0] e_fl = '0;
   int hdel = -1;
   int vchk = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h (pulse %0d)", tag, obs, exp, n_pulse);
      end
   endtask

   task automatic chk_all();
      chk("rgb_out", 32'({R_out, G_out, B_out}), 32'(e_rgb));
      chk("hsync_out", 32'(HSync_out), 32'(e_hs));
      chk("vsync_out", 32'(VSync_out), 32'(e_vs));
      chk("locked", 32'(locked), 32'(e_lock));
      chk("frame_lines", 32'(frame_lines), 32'(e_fl));
   endtask

   function automatic int sext4(input logic [3:0] v);
      int r;
      r = $signed(v);
      return r;
   endfunction

   task automatic step(input logic [CD-1:0] r, input logic [CD-1:0] g, input logic [CD-1:0] b,
                       input bit hs, input bit vs);
      int tap, m, s, vold;
      bit hsf, vsf;
      R = r; G = g; B = b; HSync = hs; VSync = vs; ce_pix = 1'b1;
      hs_hist[n_pulse] = hs;
      vs_hist[n_pulse] = vs;
      hsf  = phs_m && !hs;
      vsf  = pvs_m && !vs;
      vold = vcnt_m;
      if (hsf) begin
         cnt_m++;
         line_m++;
         if (!vs) vcnt_m++;
      end
      if (vsf) line_m = 0;
      line_hist[n_pulse] = line_m;
      // outputs of this pulse use the offsets/lock held before it
      tap  = 8 + h_m;
      m    = n_pulse - tap;
      e_hs = (m >= 0) ? hs_hist[m] : 1'b1;
      if (!lock_m || v_m == 0) begin
         e_vs = (m >= 0) ? vs_hist[m] : 1'b1;
      end else begin
         s    = (v_m > 0) ? v_m : fl_m + v_m;
         e_vs = !(m >= 0 && line_hist[m] >= s && line_hist[m] < s + vsl_m);
      end
      if (vsf) begin
         lock_m = (cnt_m == fl_m) && (cnt_m >= 16) && (cnt_m <= 2046);
         fl_m   = cnt_m;
         vsl_m  = (vold < 1) ? 1 : vold;
         cnt_m  = 0;
         vcnt_m = 0;
         h_m    = enable ? sext4(h_adj) : 0;
         v_m    = enable ? sext4(v_adj) : 0;
      end
      phs_m  = hs;
      pvs_m  = vs;
      e_lock = lock_m;
      e_fl   = LB'(fl_m);
      rgb_q.push_back({r, g, b});
      e_rgb = rgb_q.pop_front();
      @(posedge clk_sys);
      #1;
      chk_all();
      n_pulse++;
   endtask

   // 40-pixel lines, 4-pixel HS, VS low from line 0 pixel 20 to line 2 pixel 20
   task automatic do_frame(input int nl, input int mid_h);
      bit hs_v, vs_v;
      for (int l = 0; l < nl; l++) begin
         if (mid_h >= 0 && l == 10) h_adj = 4'(mid_h);
         for (int p = 0; p < 40; p++) begin
            hs_v = (p >= 4);
            vs_v = !((l == 0 && p >= 20) || l == 1 || (l == 2 && p < 20));
            step(CD'($urandom), CD'($urandom), CD'($urandom), hs_v, vs_v);
            if (hdel >= 0 && l == 5 && p == hdel)     chk("hs_out_fall", 32'(HSync_out), 32'd0);
            if (hdel >= 0 && l == 5 && p == hdel - 1) chk("hs_out_prefall", 32'(HSync_out), 32'd1);
            if (vchk != 0 && l == 1 && p == 30)       chk("vs_regen_high", 32'(VSync_out), 32'd1);
            if (vchk == 1 && l == 3 && p == 10)       chk("vs_regen_pos", 32'(VSync_out), 32'd0);
            if (vchk == 2 && l == 18 && p == 5)       chk("vs_regen_neg", 32'(VSync_out), 32'd0);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 8; i++) rgb_q.push_back('0);

      // reset held with ce_pix toggling
      for (int i = 0; i < 6; i++) begin
         ce_pix = ~ce_pix;
         R = CD'($urandom); G = CD'($urandom); B = CD'($urandom);
         @(posedge clk_sys);
         #1;
         chk_all();
      end
      reset  = 1'b0;
      ce_pix = 1'b0;
      @(posedge clk_sys);
      #1;

      // first pixel after reset appears 8 pulses later
      step(6'd1, 6'd2, 6'd3, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) step('0, '0, '0, 1'b1, 1'b1);
      chk("first_pixel", 32'({R_out, G_out, B_out}), 32'({6'd1, 6'd2, 6'd3}));

      // lock acquisition on stable 20-line frames
      do_frame(20, -1);
      do_frame(20, -1);
      chk("lock_early", 32'(locked), 32'd0);
      do_frame(20, -1);
      chk("lock_set", 32'(locked), 32'd1);
      chk("lines_20", 32'(frame_lines), 32'd20);

      // horizontal shift +3 then -8
      h_adj = 4'd3; hdel = 11;
      do_frame(20, -1);
      do_frame(20, -1);
      h_adj = 4'b1000; hdel = 0;
      do_frame(20, -1);

      // offsets disabled
      hdel = 8; enable = 1'b0; h_adj = 4'd5; v_adj = 4'd4;
      do_frame(20, -1);
      do_frame(20, -1);

      // vertical regeneration +2 then -3
      hdel = -1; enable = 1'b1; h_adj = 4'd0; v_adj = 4'd2; vchk = 1;
      do_frame(20, -1);
      do_frame(20, -1);
      v_adj = 4'b1101; vchk = 2;
      do_frame(20, -1);
      do_frame(20, -1);

      // mid-frame h_adj change is deferred to the next frame
      vchk = 0; v_adj = 4'd0; h_adj = 4'd0; hdel = 8;
      do_frame(20, 7);

      // ce_pix low: everything holds
      ce_pix = 1'b0;
      for (int i = 0; i < 10; i++) begin
         R = CD'($urandom); G = CD'($urandom); B = CD'($urandom); HSync = ~HSync;
         @(posedge clk_sys);
         #1;
         chk_all();
      end

      hdel = 15;
      do_frame(20, -1);
      hdel = -1; h_adj = 4'd0;
      do_frame(21, -1);
      do_frame(20, -1);
      chk("lock_lost", 32'(locked), 32'd0);
      chk("lines_21", 32'(frame_lines), 32'd21);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
